i2c_target: RTL and testbench
=============================

Name: i2c_target

Overview:
- I2C target (responder) for the other end of the gk110 I2C controller bus (SDA/SCL), so one gk110 board can act as a peripheral to another, and the controller gets an on-chip loopback partner.
- Samples SCL/SDA and detects START/STOP, matches a 7-bit address and ACKs it.
- Delivers written bytes on a strobe interface and fetches read bytes from a request interface.
- Drives SDA through the open-drain SB_IO tristate pattern: SDA_out is held 0 and SDA_config enables the drive.

Parameters:
ADDRESS, 7'h42, 7-bit target address matched after START
SYNC_STAGES, 2, synchroniser flops on SCL_in/SDA_in (min 2)

Ports:
cpu_clock  input  1  system clock; must be at least 16x the SCL frequency
reset  input  1  asynchronous, active-high reset
SCL_in  input  1  bus clock from pin (raw, asynchronous)
SDA_in  input  1  bus data from SB_IO D_IN_0 (raw, asynchronous)
SDA_out  output  1  constant 0 (open-drain low level)
SDA_config  output  1  1 = pull SDA low, 0 = release
rx_data  output  8  last byte written by the controller
rx_valid  output  1  one-cycle strobe, rx_data valid
tx_data  input  8  next byte to return on a read
tx_load  output  1  one-cycle strobe: tx_data captured; present the next byte
selected  output  1  high from address ACK until STOP, repeated START or NACK
stop_seen  output  1  one-cycle strobe on STOP while selected

Behaviour:
- Reset (async) values: SDA_config=0, rx_data=0, rx_valid=0, tx_load=0, selected=0, stop_seen=0, state=IDLE, synchronisers=1.
- Synchronised scl/sda plus one-cycle-delayed copies give scl_rise, scl_fall, sda_rise and sda_fall.
- START = sda_fall while scl=1. STOP = sda_rise while scl=1.
- Data bits are sampled on scl_rise, MSB first. SDA_config changes only on scl_fall, never while scl=1.
- Bit counter: 4 bits, reset to 0 on START and at each byte boundary.
- States: IDLE, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_ACK, IGNORE.
- IDLE: START -> ADDR.
- ADDR: shift 8 bits. After the 8th scl_rise, compare bits[7:1] with ADDRESS.
  - Match: on the next scl_fall assert SDA_config -> ADDR_ACK.
  - Mismatch -> IGNORE (no ACK).
- ADDR_ACK: hold SDA low through the 9th clock. On the 9th scl_fall:
  - R/W=0: release SDA -> WRITE.
  - R/W=1: capture tx_data, pulse tx_load, drive SDA_config = ~bit7 -> READ.
  - selected=1 from entry into ADDR_ACK.
- WRITE: shift 8 bits. On the 8th scl_rise, latch rx_data and pulse rx_valid the next cycle. Next scl_fall asserts ACK -> WRITE_ACK. Every write byte is ACKed.
- WRITE_ACK: on the 9th scl_fall, release -> WRITE.
- READ: on each scl_fall after a sampled bit, drive the next bit (SDA_config = ~bit). After the 8th bit's scl_fall, release -> READ_ACK.
- READ_ACK: sample the controller's bit on the 9th scl_rise.
  - ACK (0): on scl_fall capture tx_data, pulse tx_load, drive bit7 -> READ.
  - NACK (1): release, selected=0 -> IGNORE.
- IGNORE: SDA released; wait for START (-> ADDR) or STOP (-> IDLE).
- START in any state (repeated START): release SDA, clear the bit counter, selected=0 -> ADDR. It takes priority over a coincident bit event.
- STOP in any state: release SDA -> IDLE. Pulse stop_seen if selected, then clear selected.
- A partial byte at START/STOP is discarded: no rx_valid.
- tx_data is sampled only in the tx_load cycle. Consumer contract: hold tx_data stable from the previous tx_load until the next tx_load.
- Reset mid-transfer releases SDA immediately (async) and the block ignores the bus until the next START.

Test Plan:
- Write 0x84 (addr 0x42, W), then 0xA5, 0x3C, STOP -> ACK on bits 9; rx_valid twice with rx_data 0xA5 then 0x3C; stop_seen pulse; selected 1->0.
- Address 0x43 W, byte 0xFF -> no ACK (SDA_config stays 0), no rx_valid, selected=0 throughout.
- Read 0x85 with tx_data 0x5A then 0xC3; controller ACKs byte 1 and NACKs byte 2 -> bus bits 01011010 then 11000011; tx_load pulses twice; IGNORE after the NACK, SDA released.
- Write 0x84 + 0x11, repeated START, 0x85, read one byte 0x77 with NACK, STOP -> rx 0x11, then read returns 0x77; no stop_seen before the final STOP.
- Assert reset while driving an ACK low -> SDA_config=0 within the reset assertion, outputs at reset values; the following START 0x84 is ACKed normally.
- START after 4 bits of a write byte -> no rx_valid, ADDR restarts; the next address 0x84 is ACKed.

Source files
------------

// File: rtl/i2c_target.sv
// i2c_target: I2C responder with 7-bit address match, byte strobe write path
// and request/load read path, driving SDA open-drain through SDA_config.
module i2c_target #(
    parameter logic [6:0] ADDRESS     = 7'h42,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       cpu_clock,
    input  logic       reset,
    input  logic       SCL_in,
    input  logic       SDA_in,
    output logic       SDA_out,
    output logic       SDA_config,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_load,
    output logic       selected,
    output logic       stop_seen
);
    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] ADDR      = 3'd1;
    localparam logic [2:0] ADDR_ACK  = 3'd2;
    localparam logic [2:0] WRITE     = 3'd3;
    localparam logic [2:0] WRITE_ACK = 3'd4;
    localparam logic [2:0] READ      = 3'd5;
    localparam logic [2:0] READ_ACK  = 3'd6;
    localparam logic [2:0] IGNORE    = 3'd7;

    logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
    logic       scl_d, sda_d;
    logic       scl, sda;
    logic       scl_rise, scl_fall, sda_rise, sda_fall, start, stop;
    logic [2:0] state;
    logic [3:0] bit_cnt;
    logic [7:0] shift, tx_shift;
    logic       nack;

    assign SDA_out  = 1'b0;
    assign scl      = scl_sync[SYNC_STAGES-1];
    assign sda      = sda_sync[SYNC_STAGES-1];
    assign scl_rise = scl & ~scl_d;
    assign scl_fall = ~scl & scl_d;
    assign sda_rise = sda & ~sda_d;
    assign sda_fall = ~sda & sda_d;
    assign start    = sda_fall & scl;
    assign stop     = sda_rise & scl;

    always_ff @(posedge cpu_clock or posedge reset) begin
        if (reset) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], SCL_in};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], SDA_in};
            scl_d    <= scl;
            sda_d    <= sda;
        end
    end

    always_ff @(posedge cpu_clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            shift      <= '0;
            tx_shift   <= '0;
            nack       <= 1'b0;
            SDA_config <= 1'b0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            tx_load    <= 1'b0;
            selected   <= 1'b0;
            stop_seen  <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            tx_load   <= 1'b0;
            stop_seen <= 1'b0;
            if (start) begin
                SDA_config <= 1'b0;
                bit_cnt    <= '0;
                selected   <= 1'b0;
                state      <= ADDR;
            end else if (stop) begin
                SDA_config <= 1'b0;
                stop_seen  <= selected;
                selected   <= 1'b0;
                state      <= IDLE;
            end else if (scl_rise) begin
                case (state)
                    ADDR, WRITE: begin
                        shift   <= {shift[6:0], sda};
                        bit_cnt <= bit_cnt + 4'd1;
                        if (state == WRITE && bit_cnt == 4'd7) begin
                            rx_data  <= {shift[6:0], sda};
                            rx_valid <= 1'b1;
                        end
                    end
                    READ:     bit_cnt <= bit_cnt + 4'd1;
                    READ_ACK: nack <= sda;
                    default: ;
                endcase
            end else if (scl_fall) begin
                // All SDA drive changes happen here, so SDA never moves while SCL is high
                case (state)
                    ADDR: if (bit_cnt == 4'd8) begin
                        bit_cnt <= '0;
                        if (shift[7:1] == ADDRESS) begin
                            SDA_config <= 1'b1;
                            selected   <= 1'b1;
                            state      <= ADDR_ACK;
                        end else begin
                            state <= IGNORE;
                        end
                    end
                    ADDR_ACK, READ_ACK: begin
                        if ((state == ADDR_ACK && shift[0]) || (state == READ_ACK && !nack)) begin
                            tx_shift   <= tx_data;
                            tx_load    <= 1'b1;
                            SDA_config <= ~tx_data[7];
                            bit_cnt    <= '0;
                            state      <= READ;
                        end else if (state == ADDR_ACK) begin
                            SDA_config <= 1'b0;
                            state      <= WRITE;
                        end else begin
                            SDA_config <= 1'b0;
                            selected   <= 1'b0;
                            state      <= IGNORE;
                        end
                    end
                    WRITE: if (bit_cnt == 4'd8) begin
                        bit_cnt    <= '0;
                        SDA_config <= 1'b1;
                        state      <= WRITE_ACK;
                    end
                    WRITE_ACK: begin
                        SDA_config <= 1'b0;
                        state      <= WRITE;
                    end
                    READ: begin
                        if (bit_cnt == 4'd8) begin
                            bit_cnt    <= '0;
                            SDA_config <= 1'b0;
                            state      <= READ_ACK;
                        end else begin
                            SDA_config <= ~tx_shift[6];
                            tx_shift   <= {tx_shift[6:0], 1'b0};
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_i2c_target.sv
// tb_i2c_target: bit-banged I2C controller with a transaction-level model
// of what the target should ACK, deliver and return.
module tb_i2c_target;
    logic       cpu_clock = 1'b0;
    logic       reset = 1'b1;
    logic       ctrl_scl = 1'b1;
    logic       ctrl_sda = 1'b1;
    logic       sda_bus;
    logic       SDA_out, SDA_config, rx_valid, tx_load, selected, stop_seen;
    logic [7:0] rx_data;
    logic [7:0] tx_data = 8'h00;
    logic [7:0] rx_q[$], exp_rx[$], tx_q[$];
    int         errors = 0, checks = 0;
    int         n_tx = 0, n_stop = 0, viol = 0;
    logic       sel_seen = 1'b0;
    logic       cfg_prev = 1'b0;

    // Wired-AND bus: the target can only pull SDA low
    assign sda_bus = ctrl_sda & ~SDA_config;

    always #5 cpu_clock = ~cpu_clock;

    i2c_target dut (
        .cpu_clock (cpu_clock),
        .reset     (reset),
        .SCL_in    (ctrl_scl),
        .SDA_in    (sda_bus),
        .SDA_out   (SDA_out),
        .SDA_config(SDA_config),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .tx_data   (tx_data),
        .tx_load   (tx_load),
        .selected  (selected),
        .stop_seen (stop_seen)
    );

    always @(negedge cpu_clock) begin
        if (rx_valid) rx_q.push_back(rx_data);
        if (tx_load) begin
            n_tx++;
            if (tx_q.size() > 0) tx_data = tx_q.pop_front();
        end
        if (stop_seen) n_stop++;
        if (selected) sel_seen = 1'b1;
        if (!reset && ctrl_scl && SDA_config !== cfg_prev) viol++;
        cfg_prev = SDA_config;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic q();
        repeat (10) @(negedge cpu_clock);
    endtask

    task automatic i2c_start();
        ctrl_sda = 1'b1; q();
        ctrl_scl = 1'b1; q();
        ctrl_sda = 1'b0; q();
        ctrl_scl = 1'b0; q();
    endtask

    task automatic i2c_stop();
        ctrl_sda = 1'b0; q();
        ctrl_scl = 1'b1; q();
        ctrl_sda = 1'b1; q();
    endtask

    task automatic bit_io(input logic b, output logic r);
        ctrl_sda = b; q();
        ctrl_scl = 1'b1; q();
        r = sda_bus; q();
        ctrl_scl = 1'b0; q();
    endtask

    task automatic send_byte(input logic [7:0] b, output logic acked);
        logic r;
        for (int i = 7; i >= 0; i--) bit_io(b[i], r);
        bit_io(1'b1, r);
        acked = !r;
    endtask

    task automatic recv_byte(input logic ack, output logic [7:0] b);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            bit_io(1'b1, r);
            b[i] = r;
        end
        bit_io(!ack, r);
    endtask

    task automatic check_rx(input string tag);
        check({tag, "_rx_count"}, rx_q.size(), exp_rx.size());
        for (int i = 0; i < exp_rx.size() && i < rx_q.size(); i++)
            check($sformatf("%s_rx%0d", tag, i), rx_q[i], exp_rx[i]);
        rx_q.delete();
        exp_rx.delete();
    endtask

    initial begin
        logic       a, r, sel, rw;
        logic [7:0] d;
        logic [6:0] addr;
        logic [7:0] bytes[$];
        int         s0, t0, n;
        repeat (3) @(negedge cpu_clock);
        check("rst_cfg", SDA_config, 0);
        check("rst_sda_out", SDA_out, 0);
        check("rst_rx_data", rx_data, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_tx_load", tx_load, 0);
        check("rst_selected", selected, 0);
        check("rst_stop_seen", stop_seen, 0);
        reset = 1'b0;
        q();

        s0 = n_stop;
        i2c_start();
        send_byte(8'h84, a); check("t1_addr_ack", a, 1);
        check("t1_selected", selected, 1);
        send_byte(8'hA5, a); check("t1_ack1", a, 1);
        send_byte(8'h3C, a); check("t1_ack2", a, 1);
        i2c_stop();
        check("t1_stop_seen", n_stop - s0, 1);
        check("t1_deselect", selected, 0);
        exp_rx.push_back(8'hA5); exp_rx.push_back(8'h3C);
        check_rx("t1");

        sel_seen = 1'b0;
        i2c_start();
        send_byte(8'h86, a); check("t2_addr_nack", a, 0);
        send_byte(8'hFF, a); check("t2_data_nack", a, 0);
        i2c_stop();
        check("t2_never_selected", sel_seen, 0);
        check_rx("t2");

        s0 = n_stop; t0 = n_tx;
        tx_data = 8'h5A; tx_q.delete(); tx_q.push_back(8'hC3);
        i2c_start();
        send_byte(8'h85, a); check("t3_addr_ack", a, 1);
        recv_byte(1'b1, d); check("t3_byte0", d, 8'h5A);
        recv_byte(1'b0, d); check("t3_byte1", d, 8'hC3);
        check("t3_tx_loads", n_tx - t0, 2);
        check("t3_deselect", selected, 0);
        check("t3_released", SDA_config, 0);
        i2c_stop();
        check("t3_no_stop_seen", n_stop - s0, 0);

        s0 = n_stop;
        i2c_start();
        send_byte(8'h84, a); check("t4_waddr_ack", a, 1);
        send_byte(8'h11, a); check("t4_wdata_ack", a, 1);
        tx_data = 8'h77;
        i2c_start();
        check("t4_rstart_no_stop", n_stop - s0, 0);
        send_byte(8'h85, a); check("t4_raddr_ack", a, 1);
        recv_byte(1'b0, d); check("t4_read", d, 8'h77);
        i2c_stop();
        check("t4_stop_seen", n_stop - s0, 0);
        exp_rx.push_back(8'h11);
        check_rx("t4");

        i2c_start();
        for (int i = 7; i >= 0; i--) bit_io(d[0] ^ d[0] ^ (8'h84 >> i) & 1'b1, r);
        check("t5_ack_driven", SDA_config, 1);
        reset = 1'b1;
        #1;
        check("t5_async_release", SDA_config, 0);
        @(negedge cpu_clock); @(negedge cpu_clock);
        check("t5_selected", selected, 0);
        check("t5_rx_valid", rx_valid, 0);
        check("t5_tx_load", tx_load, 0);
        check("t5_rx_data", rx_data, 0);
        reset = 1'b0;
        q();
        i2c_start();
        send_byte(8'h84, a); check("t5_addr_ack", a, 1);
        i2c_stop();

        i2c_start();
        send_byte(8'h84, a); check("t6_addr_ack", a, 1);
        for (int i = 0; i < 4; i++) bit_io(i[0], r);
        i2c_start();
        send_byte(8'h84, a); check("t6_readdr_ack", a, 1);
        send_byte(8'h5E, a); check("t6_data_ack", a, 1);
        i2c_stop();
        exp_rx.push_back(8'h5E);
        check_rx("t6");

        for (int k = 0; k < 8; k++) begin
            sel  = 1'($urandom % 2);
            addr = sel ? 7'h42 : 7'((8'h43 + $urandom % 126) % 128);
            rw   = 1'($urandom % 2);
            n    = 1 + $urandom % 3;
            s0 = n_stop; t0 = n_tx;
            bytes.delete();
            for (int j = 0; j < n; j++) bytes.push_back(8'($urandom));
            if (rw && sel) begin
                tx_data = bytes[0];
                tx_q.delete();
                for (int j = 1; j < n; j++) tx_q.push_back(bytes[j]);
            end
            i2c_start();
            send_byte({addr, rw}, a); check($sformatf("r%0d_addr_ack", k), a, sel);
            for (int j = 0; j < n; j++) begin
                if (!rw) begin
                    send_byte(bytes[j], a);
                    check($sformatf("r%0d_wack%0d", k, j), a, sel);
                    if (sel) exp_rx.push_back(bytes[j]);
                end else begin
                    recv_byte(j != n - 1, d);
                    check($sformatf("r%0d_rd%0d", k, j), d, sel ? bytes[j] : 8'hFF);
                end
            end
            i2c_stop();
            check($sformatf("r%0d_stop_seen", k), n_stop - s0, sel && !rw);
            check($sformatf("r%0d_tx_loads", k), n_tx - t0, (sel && rw) ? n : 0);
            check_rx($sformatf("r%0d", k));
        end

        check("sda_change_while_scl_high", viol, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
